// File: rtl/btb_arb_pkg.sv
// Shared types and helpers for the BTB array port arbiter.
// Holds the controller state encoding and the index-width helper.
package btb_arb_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } arb_state_e;

  // Index width for an array of n frames; never below one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// Synchronous FIFO holding resolved-branch updates ({idx, data}) until the
// single-port BTB array has a free cycle to write them.
module btb_upd_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] store [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = store[rd_ptr];

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the payload storage is deliberately not reset; pointers and count
  // define which slots are live, and a reset-free array maps to plain RAM/flops.
  always_ff @(posedge CLK) begin
    if (do_push && !clear) store[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/btb_port_arbiter.sv
// Single-port BTB array sequencer: invalidate sweep after reset/flush, then
// arbitration between fetch lookups and buffered execute-stage updates.
module btb_port_arbiter
  import btb_arb_pkg::*;
#(
  parameter  int NFRAMES   = 64,
  parameter  int ENTRY_W   = 64,
  parameter  int UPD_DEPTH = 4,
  localparam int IDX_W     = idx_width(NFRAMES)
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               flush,
  input  logic               lookup_req,
  input  logic [IDX_W-1:0]   lookup_idx,
  output logic               lookup_gnt,
  output logic               lookup_valid,
  output logic [ENTRY_W-1:0] lookup_data,
  input  logic               upd_valid,
  input  logic [IDX_W-1:0]   upd_idx,
  input  logic [ENTRY_W-1:0] upd_data,
  output logic               upd_ready,
  output logic               mem_en,
  output logic               mem_wen,
  output logic [IDX_W-1:0]   mem_addr,
  output logic [ENTRY_W-1:0] mem_wdata,
  input  logic [ENTRY_W-1:0] mem_rdata,
  output logic               busy
);

  localparam int                 CNT_W    = $clog2(UPD_DEPTH) + 1;
  localparam int                 FIFO_W   = IDX_W + ENTRY_W;
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NFRAMES - 1);

  arb_state_e         state;
  arb_state_e         next_state;
  logic [IDX_W-1:0]   counter;
  logic [IDX_W-1:0]   next_counter;

  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic [FIFO_W-1:0]  fifo_head;
  logic [IDX_W-1:0]   head_idx;
  logic [ENTRY_W-1:0] head_data;

  assign head_idx  = fifo_head[ENTRY_W +: IDX_W];
  assign head_data = fifo_head[ENTRY_W-1:0];

  // No bypass when full: a full FIFO refuses updates until its head drains.
  assign upd_ready = (state == ST_RUN) && !flush && (fifo_count < CNT_W'(UPD_DEPTH));
  assign fifo_push = upd_valid && upd_ready;

  btb_upd_fifo #(
    .DEPTH (UPD_DEPTH),
    .WIDTH (FIFO_W)
  ) u_upd_fifo (
    .CLK       (CLK),
    .nRST      (nRST),
    .clear     (flush),
    .push      (fifo_push),
    .push_data ({upd_idx, upd_data}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= ST_INIT;
      counter <= '0;
    end else begin
      state   <= next_state;
      counter <= next_counter;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    next_state   = state;
    next_counter = counter;
    mem_en       = 1'b0;
    mem_wen      = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    lookup_gnt   = 1'b0;
    fifo_pop     = 1'b0;
    busy         = 1'b0;

    unique case (state)
      ST_INIT: begin
        busy         = 1'b1;
        mem_en       = 1'b1;
        mem_wen      = 1'b1;
        mem_addr     = counter;
        next_counter = counter + IDX_W'(1);
        if (flush) begin
          next_counter = '0;
        end else if (counter == LAST_IDX) begin
          next_state = ST_RUN;
        end
      end

      ST_RUN: begin
        if (flush) begin
          next_state   = ST_INIT;
          next_counter = '0;
        end else if (fifo_full) begin
          // Full FIFO takes the port even over a pending lookup.
          mem_en    = 1'b1;
          mem_wen   = 1'b1;
          mem_addr  = head_idx;
          mem_wdata = head_data;
          fifo_pop  = 1'b1;
        end else if (lookup_req) begin
          mem_en     = 1'b1;
          mem_addr   = lookup_idx;
          lookup_gnt = 1'b1;
        end else if (!fifo_empty) begin
          mem_en    = 1'b1;
          mem_wen   = 1'b1;
          mem_addr  = head_idx;
          mem_wdata = head_data;
          fifo_pop  = 1'b1;
        end
      end

      default: begin
        next_state   = ST_INIT;
        next_counter = '0;
      end
    endcase
  end

  // A read granted just before a flush still returns its (pre-flush) data.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) lookup_valid <= 1'b0;
    else       lookup_valid <= lookup_gnt;
  end

  assign lookup_data = mem_rdata;

endmodule

// File: tb/tb_btb_port_arbiter.sv
// Self-checking bench for btb_port_arbiter: directed scenarios plus random
// traffic, checked against a queue-based reference of the arbitration rules.
module tb_btb_port_arbiter;

  localparam int NFRAMES   = 64;
  localparam int ENTRY_W   = 64;
  localparam int UPD_DEPTH = 4;
  localparam int IDX_W     = 6;

  logic               CLK = 1'b0;
  logic               nRST = 1'b0;
  logic               flush = 1'b0;
  logic               lookup_req = 1'b0;
  logic [IDX_W-1:0]   lookup_idx = '0;
  logic               lookup_gnt;
  logic               lookup_valid;
  logic [ENTRY_W-1:0] lookup_data;
  logic               upd_valid = 1'b0;
  logic [IDX_W-1:0]   upd_idx = '0;
  logic [ENTRY_W-1:0] upd_data = '0;
  logic               upd_ready;
  logic               mem_en;
  logic               mem_wen;
  logic [IDX_W-1:0]   mem_addr;
  logic [ENTRY_W-1:0] mem_wdata;
  logic [ENTRY_W-1:0] mem_rdata;
  logic               busy;

  btb_port_arbiter #(
    .NFRAMES   (NFRAMES),
    .ENTRY_W   (ENTRY_W),
    .UPD_DEPTH (UPD_DEPTH)
  ) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .flush        (flush),
    .lookup_req   (lookup_req),
    .lookup_idx   (lookup_idx),
    .lookup_gnt   (lookup_gnt),
    .lookup_valid (lookup_valid),
    .lookup_data  (lookup_data),
    .upd_valid    (upd_valid),
    .upd_idx      (upd_idx),
    .upd_data     (upd_data),
    .upd_ready    (upd_ready),
    .mem_en       (mem_en),
    .mem_wen      (mem_wen),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .busy         (busy)
  );

  always #5 CLK = ~CLK;

  // Behavioural single-port SRAM macro driven by the DUT.
  logic [ENTRY_W-1:0] sram [NFRAMES];
  logic [ENTRY_W-1:0] rdata_q = '0;
  always @(posedge CLK) begin
    if (nRST && mem_en) begin
      if (mem_wen) sram[mem_addr] <= mem_wdata;
      else         rdata_q        <= sram[mem_addr];
    end
  end
  assign mem_rdata = rdata_q;

  // Reference model: expected array contents, pending-update queue, sweep position.
  typedef struct packed {
    logic [IDX_W-1:0]   idx;
    logic [ENTRY_W-1:0] data;
  } upd_t;

  logic [ENTRY_W-1:0] ref_arr [NFRAMES];
  upd_t               upd_q [$];
  bit                 m_init;
  int                 m_cnt;
  bit                 m_lv;
  logic [ENTRY_W-1:0] m_ld;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_in(input bit f, input bit lr, input int li,
                        input bit uv, input int ui, input logic [63:0] ud);
    flush      = f;
    lookup_req = lr;
    lookup_idx = IDX_W'(li);
    upd_valid  = uv;
    upd_idx    = IDX_W'(ui);
    upd_data   = ud;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Called #1 after a rising edge with inputs applied; checks at the falling
  // edge, advances the model, and returns #1 after the next rising edge.
  task automatic step();
    bit               e_en, e_wen, e_gnt, e_rdy, e_busy;
    logic [IDX_W-1:0] e_addr;
    logic [63:0]      e_wd;
    int               qs;
    upd_t             u;
    @(negedge CLK);
    qs     = upd_q.size();
    e_en   = 0; e_wen = 0; e_gnt = 0; e_busy = 0;
    e_addr = '0; e_wd = '0;
    e_rdy  = !m_init && !flush && (qs < UPD_DEPTH);
    if (m_init) begin
      e_busy = 1; e_en = 1; e_wen = 1; e_addr = IDX_W'(m_cnt);
    end else if (flush) begin
      e_en = 0;
    end else if (qs == UPD_DEPTH) begin
      e_en = 1; e_wen = 1; e_addr = upd_q[0].idx; e_wd = upd_q[0].data;
    end else if (lookup_req) begin
      e_en = 1; e_gnt = 1; e_addr = lookup_idx;
    end else if (qs > 0) begin
      e_en = 1; e_wen = 1; e_addr = upd_q[0].idx; e_wd = upd_q[0].data;
    end

    check("lookup_gnt", 64'(lookup_gnt), 64'(e_gnt));
    check("upd_ready", 64'(upd_ready), 64'(e_rdy));
    check("busy", 64'(busy), 64'(e_busy));
    check("mem_en", 64'(mem_en), 64'(e_en));
    if (e_en) begin
      check("mem_wen", 64'(mem_wen), 64'(e_wen));
      check("mem_addr", 64'(mem_addr), 64'(e_addr));
      if (e_wen) check("mem_wdata", mem_wdata, e_wd);
    end
    check("lookup_valid", 64'(lookup_valid), 64'(m_lv));
    if (m_lv) check("lookup_data", lookup_data, m_ld);

    if (e_en && e_wen) ref_arr[e_addr] = e_wd;
    if (m_init) begin
      if (flush)                     m_cnt = 0;
      else if (m_cnt == NFRAMES - 1) begin m_init = 0; m_cnt = 0; end
      else                           m_cnt++;
    end else if (flush) begin
      upd_q.delete();
      m_init = 1;
      m_cnt  = 0;
    end else if (e_en && e_wen) begin
      void'(upd_q.pop_front());
    end
    m_lv = e_gnt;
    if (e_gnt) m_ld = ref_arr[lookup_idx];
    if (upd_valid && e_rdy) begin
      u.idx  = upd_idx;
      u.data = upd_data;
      upd_q.push_back(u);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      set_in(0, 0, 0, 0, 0, '0);
      step();
    end
  endtask

  // Asserts reset away from any clock edge, checks the reset outputs, then releases.
  task automatic do_reset();
    set_in(0, 0, 0, 0, 0, '0);
    nRST = 1'b0;
    #2;
    check("rst_lookup_valid", 64'(lookup_valid), 64'd0);
    check("rst_lookup_gnt", 64'(lookup_gnt), 64'd0);
    check("rst_upd_ready", 64'(upd_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd1);
    check("rst_mem_en", 64'(mem_en), 64'd1);
    check("rst_mem_wen", 64'(mem_wen), 64'd1);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", mem_wdata, 64'd0);
    @(posedge CLK);
    #1;
    nRST   = 1'b1;
    m_init = 1;
    m_cnt  = 0;
    m_lv   = 0;
    upd_q.delete();
  endtask

  // Idles until the sweep ends; returns the number of busy cycles seen.
  task automatic wait_sweep(output int cycles);
    cycles = 0;
    while (busy && cycles < 200) begin
      set_in(0, 0, 0, 0, 0, '0);
      step();
      cycles++;
    end
  endtask

  initial begin
    int               n;
    logic [63:0]      da, db;
    for (int i = 0; i < NFRAMES; i++) begin
      sram[i]    = rnd64();
      ref_arr[i] = sram[i];
    end
    m_init = 1; m_cnt = 0; m_lv = 0; m_ld = '0;
    @(posedge CLK);
    #1;
    do_reset();

    // Sweep after reset, with traffic that must not be granted or accepted.
    for (int i = 0; i < NFRAMES; i++) begin
      set_in(0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 63)),
             1'($urandom_range(0, 1)), int'($urandom_range(0, 63)), rnd64());
      step();
    end
    check("sweep_busy_low", 64'(busy), 64'd0);
    check("sweep_ready_high", 64'(upd_ready), 64'd1);

    // One queued update to idx 5, then a lookup of idx 9 wins the port.
    set_in(0, 0, 0, 1, 5, 64'h5555_0000_0000_0005); step();
    set_in(0, 1, 9, 0, 0, '0); step();
    idle(3);

    // Fill the FIFO while lookups are held high.
    for (int i = 0; i < 7; i++) begin
      set_in(0, 1, int'($urandom_range(0, 63)), 1, 10 + i, rnd64());
      step();
    end
    idle(6);

    // Two updates to idx 3: the later one must win.
    da = 64'hAAAA_AAAA_0000_0003;
    db = 64'hBBBB_BBBB_0000_0003;
    set_in(0, 0, 0, 1, 3, da); step();
    set_in(0, 0, 0, 1, 3, db); step();
    idle(4);
    set_in(0, 1, 3, 0, 0, '0); step();
    check("idx3_last_wins", lookup_data, db);
    idle(1);

    // Flush with three updates queued behind held lookups.
    for (int i = 0; i < 3; i++) begin
      set_in(0, 1, int'($urandom_range(0, 63)), 1, 20 + i, rnd64());
      step();
    end
    set_in(1, 0, 0, 0, 0, '0); step();
    wait_sweep(n);
    check("flush_sweep_len", 64'(n), 64'(NFRAMES));

    // Flush re-asserted at sweep position 40 restarts the sweep.
    set_in(1, 0, 0, 0, 0, '0); step();
    n = 0;
    while (m_cnt != 40 && n < 100) begin
      set_in(0, 0, 0, 0, 0, '0); step(); n++;
    end
    set_in(1, 0, 0, 0, 0, '0); step();
    wait_sweep(n);
    check("reflush_sweep_len", 64'(n), 64'(NFRAMES));

    // Random traffic with a mid-run asynchronous reset.
    for (int i = 0; i < 4000; i++) begin
      int lp, up;
      lp = (i / 500) % 2 == 0 ? 30 : 85;
      up = (i / 250) % 3 == 0 ? 90 : 40;
      if (i == 2000) do_reset();
      set_in(1'($urandom_range(0, 199) == 0),
             1'($urandom_range(0, 99) < lp), int'($urandom_range(0, 63)),
             1'($urandom_range(0, 99) < up),
             ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 63)),
             rnd64());
      step();
    end

    // Drain and compare the whole array against the model.
    n = 0;
    while ((busy || upd_q.size() != 0) && n < 300) begin
      set_in(0, 0, 0, 0, 0, '0); step(); n++;
    end
    check("drain_idle", 64'(busy), 64'd0);
    for (int i = 0; i < NFRAMES; i++) check($sformatf("array[%0d]", i), sram[i], ref_arr[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
